spirsp: RTL

- Card-side (SPI-mode SD) command responder; the far end of the host command sender on the same shared-SPI link.
- Consumes command bytes from a low-level SPI slave byte interface and checks framing and CRC7.
- Hands each accepted command to card logic, then returns R1, R1b, R3 or R7 responses byte by byte.
- Used as the device model in benches and as the front end of SD-card emulation targets.

---
 rtl/spisd_pkg.sv | 11 +
 rtl/spirsp_if.sv | 25 ++
 rtl/spicrc7_byte.sv | 14 +
 rtl/spirsp.sv | 140 ++++++++++++++
 4 files changed

// File: rtl/spisd_pkg.sv
// spisd_pkg: shared SPI-mode SD encodings for the command sender and responder.
package spisd_pkg;
  localparam logic [1:0] RSP_R1 = 2'b00;
  localparam logic [1:0] RSP_R1B = 2'b01;
  localparam logic [1:0] RSP_R37 = 2'b10;
  localparam int R1_IDLE = 0;
  localparam int R1_ILLEGAL_CMD = 2;
  localparam int R1_COM_CRC_ERR = 3;
  localparam logic [6:0] CRC7_POLY = 7'h09;
  typedef enum logic [2:0] {ST_IDLE, ST_CMD, ST_NCR, ST_WAIT, ST_RSP, ST_BUSY} state_t;
endpackage

// File: rtl/spirsp_if.sv
// spirsp_if: byte-level SPI link plus card-logic command/response handshake.
interface spirsp_if;
  logic i_ll_sel;
  logic i_ll_stb;
  logic [7:0] i_ll_byte;
  logic [7:0] o_ll_byte;
  logic o_cmd_stb;
  logic [5:0] o_cmd;
  logic [31:0] o_cmd_arg;
  logic o_crc_err;
  logic i_rsp_stb;
  logic [1:0] i_rsp_type;
  logic [7:0] i_rsp_r1;
  logic [31:0] i_rsp_data;
  logic i_card_busy;
  logic o_busy;
  modport master (
    output i_ll_sel, i_ll_stb, i_ll_byte, i_rsp_stb, i_rsp_type, i_rsp_r1, i_rsp_data, i_card_busy,
    input o_ll_byte, o_cmd_stb, o_cmd, o_cmd_arg, o_crc_err, o_busy
  );
  modport slave (
    input i_ll_sel, i_ll_stb, i_ll_byte, i_rsp_stb, i_rsp_type, i_rsp_r1, i_rsp_data, i_card_busy,
    output o_ll_byte, o_cmd_stb, o_cmd, o_cmd_arg, o_crc_err, o_busy
  );
endinterface

// File: rtl/spicrc7_byte.sv
// spicrc7_byte: combinational CRC7 (x^7+x^3+1) advance over one byte, MSB first.
module spicrc7_byte
  import spisd_pkg::*;
(
  input  logic [6:0] crc_in,
  input  logic [7:0] data,
  output logic [6:0] crc_out
);
  always_comb begin
    crc_out = crc_in;
    for (int i = 7; i >= 0; i--)
      crc_out = {crc_out[5:0], 1'b0} ^ ((crc_out[6] ^ data[i]) ? CRC7_POLY : 7'd0);
  end
endmodule

// File: rtl/spirsp.sv
// spirsp: SPI-mode SD card-side command receiver and R1/R1b/R3/R7 responder.
module spirsp
  import spisd_pkg::*;
#(
  parameter int NCR = 1,
  parameter bit OPT_CRC = 1'b1
) (
  input logic i_clk,
  input logic i_reset_n,
  spirsp_if.slave bus
);
  localparam logic [2:0] NCR_LOAD = 3'(NCR - 1);
  state_t state, state_d;
  logic [2:0] cnt, cnt_d;
  logic [6:0] crc, crc_d, crc_nx;
  logic [5:0] cmd_q, cmd_q_d, cmd_o_d;
  logic [31:0] arg_q, arg_q_d, arg_o_d, dat_q, dat_q_d;
  logic [7:0] tx_d, r1_q, r1_q_d;
  logic [1:0] typ_q, typ_q_d;
  logic rsp_v, rsp_v_d, busy_d, cmd_stb_d, crc_err_d, frame_ok;

  spicrc7_byte u_crc (
    .crc_in(state == ST_IDLE ? 7'd0 : crc),
    .data(bus.i_ll_byte),
    .crc_out(crc_nx)
  );

  assign frame_ok = bus.i_ll_byte[0] && (!OPT_CRC || bus.i_ll_byte[7:1] == crc);

  always_comb begin
    state_d = state;
    cnt_d = cnt;
    crc_d = crc;
    cmd_q_d = cmd_q;
    arg_q_d = arg_q;
    dat_q_d = dat_q;
    cmd_o_d = bus.o_cmd;
    arg_o_d = bus.o_cmd_arg;
    tx_d = bus.o_ll_byte;
    r1_q_d = r1_q;
    typ_q_d = typ_q;
    rsp_v_d = rsp_v;
    busy_d = bus.o_busy;
    cmd_stb_d = 1'b0;
    crc_err_d = 1'b0;
    if ((state == ST_NCR || state == ST_WAIT) && !rsp_v && bus.i_rsp_stb) begin
      rsp_v_d = 1'b1;
      r1_q_d = bus.i_rsp_r1;
      typ_q_d = bus.i_rsp_type;
      dat_q_d = bus.i_rsp_data;
    end
    if (!bus.i_ll_sel) begin
      state_d = ST_IDLE;
      tx_d = 8'hff;
      busy_d = 1'b0;
      rsp_v_d = 1'b0;
    end else if (bus.i_ll_stb) begin
      case (state)
        ST_IDLE: if (bus.i_ll_byte[7:6] == 2'b01) begin
          state_d = ST_CMD;
          cnt_d = '0;
          crc_d = crc_nx;
          cmd_q_d = bus.i_ll_byte[5:0];
          busy_d = 1'b1;
        end
        ST_CMD: if (cnt != 3'd4) begin
          cnt_d = cnt + 3'd1;
          crc_d = crc_nx;
          arg_q_d = {arg_q[23:0], bus.i_ll_byte};
        end else begin
          // a rejected command still answers, with a locally built COM_CRC_ERR R1
          state_d = ST_NCR;
          cnt_d = NCR_LOAD;
          cmd_stb_d = frame_ok;
          crc_err_d = !frame_ok;
          cmd_o_d = frame_ok ? cmd_q : bus.o_cmd;
          arg_o_d = frame_ok ? arg_q : bus.o_cmd_arg;
          rsp_v_d = !frame_ok;
          r1_q_d = frame_ok ? r1_q : 8'(1 << R1_COM_CRC_ERR);
          typ_q_d = frame_ok ? typ_q : RSP_R1;
        end
        ST_NCR, ST_WAIT: if (state == ST_NCR && cnt != 3'd0) cnt_d = cnt - 3'd1;
          else if (rsp_v) begin
            state_d = ST_RSP;
            tx_d = r1_q;
            cnt_d = '0;
            rsp_v_d = 1'b0;
          end else state_d = ST_WAIT;
        ST_RSP, ST_BUSY: if (typ_q[1] && cnt != 3'd4) begin
          tx_d = dat_q[31:24];
          dat_q_d = {dat_q[23:0], 8'h00};
          cnt_d = cnt + 3'd1;
        end else if (typ_q == RSP_R1B && bus.i_card_busy) begin
          state_d = ST_BUSY;
          tx_d = 8'h00;
        end else begin
          state_d = ST_IDLE;
          tx_d = 8'hff;
          busy_d = 1'b0;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n)
    if (!i_reset_n) begin
      state <= ST_IDLE;
      cnt <= '0;
      crc <= '0;
      cmd_q <= '0;
      arg_q <= '0;
      dat_q <= '0;
      r1_q <= '0;
      typ_q <= RSP_R1;
      rsp_v <= 1'b0;
      bus.o_ll_byte <= 8'hff;
      bus.o_cmd_stb <= 1'b0;
      bus.o_crc_err <= 1'b0;
      bus.o_busy <= 1'b0;
      bus.o_cmd <= '0;
      bus.o_cmd_arg <= '0;
    end else begin
      state <= state_d;
      cnt <= cnt_d;
      crc <= crc_d;
      cmd_q <= cmd_q_d;
      arg_q <= arg_q_d;
      dat_q <= dat_q_d;
      r1_q <= r1_q_d;
      typ_q <= typ_q_d;
      rsp_v <= rsp_v_d;
      bus.o_ll_byte <= tx_d;
      bus.o_cmd_stb <= cmd_stb_d;
      bus.o_crc_err <= crc_err_d;
      bus.o_busy <= busy_d;
      bus.o_cmd <= cmd_o_d;
      bus.o_cmd_arg <= arg_o_d;
    end
endmodule
